// File: rtl/st_symbol_packer.sv
// Avalon-ST narrow-to-wide adapter: packs symbols into wide beats, carrying SOP/EOP
// through and generating the empty count on the final beat of a packet.
module st_symbol_packer #(
   parameter int unsigned SYMBOL_WIDTH     = 8,
   parameter int unsigned SYMBOLS_PER_BEAT = 4,
   parameter int unsigned EMPTY_WIDTH      = 2
) (
   input  logic                                     clk,
   input  logic                                     reset_n,
   input  logic [SYMBOL_WIDTH-1:0]                  in_data,
   input  logic                                     in_valid,
   output logic                                     in_ready,
   input  logic                                     in_startofpacket,
   input  logic                                     in_endofpacket,
   output logic [SYMBOL_WIDTH*SYMBOLS_PER_BEAT-1:0] out_data,
   output logic                                     out_valid,
   input  logic                                     out_ready,
   output logic                                     out_startofpacket,
   output logic                                     out_endofpacket,
   output logic [EMPTY_WIDTH-1:0]                   out_empty
);

   localparam int unsigned BeatWidth = SYMBOL_WIDTH * SYMBOLS_PER_BEAT;
   localparam logic [EMPTY_WIDTH-1:0] LastLane = EMPTY_WIDTH'(SYMBOLS_PER_BEAT - 1);

   logic [BeatWidth-1:0]   acc_q, acc_d, acc_wr;
   logic [EMPTY_WIDTH-1:0] count_q, count_d, lane;
   logic                   in_packet_q, in_packet_d;
   logic                   sop_pending_q, sop_pending_d;
   logic                   ready_en_q;
   logic [BeatWidth-1:0]   out_data_q, out_data_d;
   logic                   out_valid_q, out_valid_d;
   logic                   out_sop_q, out_sop_d;
   logic                   out_eop_q, out_eop_d;
   logic [EMPTY_WIDTH-1:0] out_empty_q, out_empty_d;
   logic                   accept, in_pkt, commit;

   assign in_ready = ready_en_q & (~out_valid_q | out_ready);
   assign accept   = in_valid & in_ready;
   assign in_pkt   = in_startofpacket | in_packet_q;
   assign commit   = accept & in_pkt & ((lane == LastLane) | in_endofpacket);

   always_comb begin
      // An SOP restarts at lane 0 and drops any partial accumulation.
      lane   = in_startofpacket ? '0 : count_q;
      acc_wr = in_startofpacket ? '0 : acc_q;
      for (int unsigned k = 0; k < SYMBOLS_PER_BEAT; k++) begin
         if (lane == EMPTY_WIDTH'(k)) begin
            acc_wr[BeatWidth-1-SYMBOL_WIDTH*k -: SYMBOL_WIDTH] = in_data;
         end
      end
   end

   always_comb begin
      acc_d         = acc_q;
      count_d       = count_q;
      in_packet_d   = in_packet_q;
      sop_pending_d = sop_pending_q;
      out_data_d    = out_data_q;
      out_valid_d   = out_valid_q;
      out_sop_d     = out_sop_q;
      out_eop_d     = out_eop_q;
      out_empty_d   = out_empty_q;
      if (accept && in_pkt) begin
         if (commit) begin
            acc_d         = '0;
            count_d       = '0;
            sop_pending_d = 1'b0;
            in_packet_d   = ~in_endofpacket;
         end else begin
            acc_d         = acc_wr;
            count_d       = lane + 1'b1;
            sop_pending_d = sop_pending_q | in_startofpacket;
            in_packet_d   = 1'b1;
         end
      end
      if (commit) begin
         out_data_d  = acc_wr;
         out_valid_d = 1'b1;
         out_sop_d   = sop_pending_q | in_startofpacket;
         out_eop_d   = in_endofpacket;
         out_empty_d = in_endofpacket ? LastLane - lane : '0;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc_q         <= '0;
         count_q       <= '0;
         in_packet_q   <= 1'b0;
         sop_pending_q <= 1'b0;
         ready_en_q    <= 1'b0;
         out_data_q    <= '0;
         out_valid_q   <= 1'b0;
         out_sop_q     <= 1'b0;
         out_eop_q     <= 1'b0;
         out_empty_q   <= '0;
      end else begin
         acc_q         <= acc_d;
         count_q       <= count_d;
         in_packet_q   <= in_packet_d;
         sop_pending_q <= sop_pending_d;
         ready_en_q    <= 1'b1;
         out_data_q    <= out_data_d;
         out_valid_q   <= out_valid_d;
         out_sop_q     <= out_sop_d;
         out_eop_q     <= out_eop_d;
         out_empty_q   <= out_empty_d;
      end
   end

   assign out_data          = out_data_q;
   assign out_valid         = out_valid_q;
   assign out_startofpacket = out_sop_q;
   assign out_endofpacket   = out_eop_q;
   assign out_empty         = out_empty_q;

endmodule
